// File: rtl/mul_operand_sequencer.sv
// Operand sequencer for the 16x16 multiply path: captures two operand pairs and
// issues their four byte-slice partial products to a pair of 8x8 multiplier lanes.

module mul_operand_lane #(
  parameter int SLICE_W = 8,
  parameter int OP_W    = 16
) (
  input  logic [OP_W-1:0]    a,
  input  logic [OP_W-1:0]    b,
  input  logic [1:0]         idx,
  input  logic               en,
  output logic [SLICE_W-1:0] mul_a,
  output logic [SLICE_W-1:0] mul_b
);
  // idx[1] selects the A byte, idx[0] the B byte: L*L, L*H, H*L, H*H
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (en) begin
      mul_a = idx[1] ? a[OP_W-1:SLICE_W] : a[SLICE_W-1:0];
      mul_b = idx[0] ? b[OP_W-1:SLICE_W] : b[SLICE_W-1:0];
    end
  end
endmodule

module mul_operand_sequencer #(
  parameter int SLICE_W = 8,
  parameter int OP_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [OP_W-1:0]    op_a1,
  input  logic [OP_W-1:0]    op_b1,
  input  logic [OP_W-1:0]    op_a2,
  input  logic [OP_W-1:0]    op_b2,
  input  logic               acc_ready,
  output logic               slice_valid,
  output logic [SLICE_W-1:0] mul_a1,
  output logic [SLICE_W-1:0] mul_b1,
  output logic [SLICE_W-1:0] mul_a2,
  output logic [SLICE_W-1:0] mul_b2,
  output logic [1:0]         pp_idx,
  output logic [4:0]         pp_shift,
  output logic               pp_last,
  output logic               busy,
  output logic               done
);
  localparam int NUM_LANES = 2;

  generate
    if (OP_W != 2 * SLICE_W) begin : g_bad_width
      $error("mul_operand_sequencer: OP_W must equal 2*SLICE_W");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  typedef struct packed {
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } opnd_t;

  state_t                    state_q, state_d;
  logic [1:0]                idx_q, idx_d;
  logic                      done_q, done_d;
  opnd_t [NUM_LANES-1:0]     op_in, op_q, op_d;
  logic [NUM_LANES-1:0][SLICE_W-1:0] lane_a, lane_b;

  assign op_in[0] = {op_a1, op_b1};
  assign op_in[1] = {op_a2, op_b2};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_in;
          idx_d   = 2'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (acc_ready) begin
          if (idx_q == 2'd3) begin
            idx_d   = 2'd0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      S_DONE: begin
        // level protocol: issuer must drop start before we rearm
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      op_q    <= op_d;
    end
  end

  assign slice_valid = (state_q == S_ISSUE);
  assign busy        = slice_valid;
  assign done        = done_q;

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      mul_operand_lane #(.SLICE_W(SLICE_W), .OP_W(OP_W)) u_lane (
        .a     (op_q[g].a),
        .b     (op_q[g].b),
        .idx   (idx_q),
        .en    (slice_valid),
        .mul_a (lane_a[g]),
        .mul_b (lane_b[g])
      );
    end
  endgenerate

  assign mul_a1 = lane_a[0];
  assign mul_b1 = lane_b[0];
  assign mul_a2 = lane_a[1];
  assign mul_b2 = lane_b[1];

  // weight is one slice per high byte selected: 0, S, S, 2S
  always_comb begin
    pp_idx   = 2'd0;
    pp_shift = 5'd0;
    pp_last  = 1'b0;
    if (slice_valid) begin
      pp_idx   = idx_q;
      pp_last  = (idx_q == 2'd3);
      pp_shift = (idx_q[1] ? 5'(SLICE_W) : 5'd0) + (idx_q[0] ? 5'(SLICE_W) : 5'd0);
    end
  end
endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Bench for mul_operand_sequencer: table vectors, hand corner sequences and
// randomized operations against a slice/product reference model.

module tb_mul_operand_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] op_a1 = '0, op_b1 = '0, op_a2 = '0, op_b2 = '0;
  logic        acc_ready = 1'b0;
  logic        slice_valid, pp_last, busy, done;
  logic [7:0]  mul_a1, mul_b1, mul_a2, mul_b2;
  logic [1:0]  pp_idx;
  logic [4:0]  pp_shift;

  int total = 0;
  int bad = 0;

  mul_operand_sequencer #(.SLICE_W(8), .OP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a1(op_a1), .op_b1(op_b1), .op_a2(op_a2), .op_b2(op_b2),
    .acc_ready(acc_ready), .slice_valid(slice_valid),
    .mul_a1(mul_a1), .mul_b1(mul_b1), .mul_a2(mul_a2), .mul_b2(mul_b2),
    .pp_idx(pp_idx), .pp_shift(pp_shift), .pp_last(pp_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_valid"}, {31'd0, slice_valid}, 0);
    chk({tag, "_busy"},  {31'd0, busy}, 0);
    chk({tag, "_mul"},   {mul_a1, mul_b1, mul_a2, mul_b2}, 0);
    chk({tag, "_pp"},    {24'd0, pp_idx, pp_shift, pp_last}, 0);
  endtask

  // Reference: slice k takes byte (k/2) of A and byte (k%2) of B, weight = 8*(bytes)
  function automatic logic [7:0] ref_byte(input logic [15:0] v, input int sel);
    return 8'((v >> (8 * sel)) & 16'h00FF);
  endfunction

  // rmode: 0 ready always, 1 random ready, 2 stall 3 cycles on slice 1
  task automatic run_op(input logic [15:0] a1, b1, a2, b2, input int rmode, input bit hold,
                        output logic [31:0] s1, output logic [31:0] s2, output int edges);
    int k, stalls;
    bit seen_done;
    start = 1'b0;
    acc_ready = 1'b0;
    step();
    chk("idle_done", {31'd0, done}, 0);
    chk_quiet("idle");
    op_a1 = a1; op_b1 = b1; op_a2 = a2; op_b2 = b2;
    start = 1'b1;
    step();
    edges = 1;
    if (!hold) start = 1'b0;
    // operands scrambled after capture must not leak into the slices
    op_a1 = 16'hAAAA; op_b1 = 16'(~b1); op_a2 = 16'($urandom); op_b2 = 16'($urandom);
    k = 0; stalls = 0; s1 = 0; s2 = 0; seen_done = 0;
    for (int c = 0; c < 200; c++) begin
      if (!slice_valid) begin
        seen_done = 1;
        break;
      end
      if (k > 3) begin
        chk("extra_slice", k, 4);
        break;
      end
      chk("a1", mul_a1, ref_byte(a1, k / 2));
      chk("b1", mul_b1, ref_byte(b1, k % 2));
      chk("a2", mul_a2, ref_byte(a2, k / 2));
      chk("b2", mul_b2, ref_byte(b2, k % 2));
      chk("idx", pp_idx, k);
      chk("shift", pp_shift, 8 * (k / 2 + k % 2));
      chk("last", pp_last, (k == 3));
      chk("busy", {busy, done}, 2'b10);
      case (rmode)
        0: acc_ready = 1'b1;
        1: acc_ready = ($urandom_range(0, 2) != 0);
        default: begin
          acc_ready = !(k == 1 && stalls < 3);
          if (!acc_ready) stalls++;
        end
      endcase
      if (acc_ready) begin
        s1 += (32'(mul_a1) * 32'(mul_b1)) << pp_shift;
        s2 += (32'(mul_a2) * 32'(mul_b2)) << pp_shift;
        k++;
      end
      step();
      edges++;
    end
    acc_ready = 1'b0;
    if (!seen_done) chk("timeout", 0, 1);
    chk("slice_count", k, 4);
    chk("done_hi", {31'd0, done}, 1);
    chk_quiet("done");
  endtask

  typedef struct {
    logic [15:0] a1, b1, a2, b2;
    logic [31:0] s1, s2;
    int          done_at;
  } vec_t;

  vec_t vecs[3];
  logic [31:0] s1, s2;
  int edges;
  logic [15:0] ra1, rb1, ra2, rb2;

  initial begin
    vecs[0] = '{16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF, 32'h06260060, 32'hFFFE0001, 5};
    vecs[1] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h0002, 32'h00000000, 32'h00010000, 5};
    vecs[2] = '{16'h00FF, 16'hFF00, 16'h0101, 16'h0101, 32'h00FE0100, 32'h00010201, 5};

    #12;
    chk("rst_done", {31'd0, done}, 0);
    chk_quiet("rst");
    step();
    rst_n = 1'b1;
    step();
    chk_quiet("post_rst");

    for (int i = 0; i < 3; i++) begin
      run_op(vecs[i].a1, vecs[i].b1, vecs[i].a2, vecs[i].b2, 0, 0, s1, s2, edges);
      chk("vec_sum1", s1, vecs[i].s1);
      chk("vec_sum2", s2, vecs[i].s2);
      chk("vec_done_at", edges, vecs[i].done_at);
    end

    // backpressure on slice 1
    run_op(16'h1234, 16'h5678, 16'hFFFF, 16'hFFFF, 2, 0, s1, s2, edges);
    chk("bp_sum1", s1, 32'h06260060);
    chk("bp_done_at", edges, 8);

    // start held through DONE must not retrigger
    run_op(16'h1234, 16'h5678, 16'h0003, 16'h0005, 0, 1, s1, s2, edges);
    chk("hold_sum2", s2, 15);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("hold_done", {31'd0, done}, 1);
      chk("hold_valid", {31'd0, slice_valid}, 0);
    end
    run_op(16'h4321, 16'h0010, 16'h0002, 16'h0002, 0, 0, s1, s2, edges);
    chk("rearm_sum1", s1, 32'h00043210);
    chk("rearm_done_at", edges, 5);

    // reset in the middle of an issue sequence
    start = 1'b0;
    step();
    op_a1 = 16'h1234; op_b1 = 16'h5678; op_a2 = 16'hFFFF; op_b2 = 16'hFFFF;
    start = 1'b1;
    step();
    start = 1'b0;
    acc_ready = 1'b1;
    step();
    step();
    acc_ready = 1'b0;
    chk("mid_idx", pp_idx, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_done", {31'd0, done}, 0);
    chk_quiet("mid_rst");
    step();
    step();
    rst_n = 1'b1;
    acc_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_quiet("after_rst");
      chk("after_rst_done", {31'd0, done}, 0);
    end

    // randomized operations with random backpressure
    for (int i = 0; i < 25; i++) begin
      ra1 = 16'($urandom); rb1 = 16'($urandom);
      ra2 = 16'($urandom); rb2 = 16'($urandom);
      run_op(ra1, rb1, ra2, rb2, 1, 0, s1, s2, edges);
      chk("rnd_prod1", s1, 32'(ra1) * 32'(rb1));
      chk("rnd_prod2", s2, 32'(ra2) * 32'(rb2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end
endmodule
